// File: rtl/line_seg_raster.sv
// ============================================================================
// Module   : line_seg_raster
// Brief    : 3-stage pixel-vs-segment hit tester with double-buffered geometry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_seg_raster #(
    parameter int COORD_W = 16,
    parameter int NUM_SEG = 4,
    parameter int THRESH  = 1024,
    parameter int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 px_valid,
    input  logic [COORD_W-1:0]   px_x,
    input  logic [COORD_W-1:0]   px_y,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [COORD_W-1:0]   cfg_ax,
    input  logic [COORD_W-1:0]   cfg_ay,
    input  logic [COORD_W-1:0]   cfg_bx,
    input  logic [COORD_W-1:0]   cfg_by,
    input  logic                 cfg_en,
    output logic                 out_valid,
    output logic [COORD_W-1:0]   out_x,
    output logic [COORD_W-1:0]   out_y,
    output logic                 hit,
    output logic [NUM_SEG-1:0]   hit_mask,
    output logic [IDX_W-1:0]     hit_idx
);

    localparam int                       c_xw      = 2 * COORD_W + 3;
    localparam logic [IDX_W:0]           c_num_seg = NUM_SEG[IDX_W:0];
    localparam logic signed [c_xw-1:0]   c_thresh  = c_xw'(THRESH);

    logic signed [COORD_W-1:0] r_sh_ax [NUM_SEG];
    logic signed [COORD_W-1:0] r_sh_ay [NUM_SEG];
    logic signed [COORD_W-1:0] r_sh_bx [NUM_SEG];
    logic signed [COORD_W-1:0] r_sh_by [NUM_SEG];
    logic        [NUM_SEG-1:0] r_sh_en;
    logic signed [COORD_W-1:0] r_ac_ax [NUM_SEG];
    logic signed [COORD_W-1:0] r_ac_ay [NUM_SEG];
    logic signed [COORD_W-1:0] r_ac_bx [NUM_SEG];
    logic signed [COORD_W-1:0] r_ac_by [NUM_SEG];
    logic        [NUM_SEG-1:0] r_ac_en;

    logic signed [COORD_W-1:0] w_px;
    logic signed [COORD_W-1:0] w_py;
    logic                      r1_valid, r2_valid;
    logic        [COORD_W-1:0] r1_x, r1_y, r2_x, r2_y;
    logic        [NUM_SEG-1:0] w_mask;
    logic        [NUM_SEG-1:0] w_mask_q;
    logic        [IDX_W-1:0]   w_idx;

    assign w_px = px_x;
    assign w_py = px_y;

    // Commit reads shadow with pre-write contents because both use NBAs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                r_sh_ax[i] <= '0;
                r_sh_ay[i] <= '0;
                r_sh_bx[i] <= '0;
                r_sh_by[i] <= '0;
                r_ac_ax[i] <= '0;
                r_ac_ay[i] <= '0;
                r_ac_bx[i] <= '0;
                r_ac_by[i] <= '0;
            end
            r_sh_en <= '0;
            r_ac_en <= '0;
        end else begin
            if (cfg_we && ({1'b0, cfg_idx} < c_num_seg)) begin
                r_sh_ax[cfg_idx] <= cfg_ax;
                r_sh_ay[cfg_idx] <= cfg_ay;
                r_sh_bx[cfg_idx] <= cfg_bx;
                r_sh_by[cfg_idx] <= cfg_by;
                r_sh_en[cfg_idx] <= cfg_en;
            end
            if (frame_start) begin
                for (int i = 0; i < NUM_SEG; i++) begin
                    r_ac_ax[i] <= r_sh_ax[i];
                    r_ac_ay[i] <= r_sh_ay[i];
                    r_ac_bx[i] <= r_sh_bx[i];
                    r_ac_by[i] <= r_sh_by[i];
                end
                r_ac_en <= r_sh_en;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SEG; g++) begin : g_seg
            logic signed [COORD_W-1:0] w_minx, w_maxx, w_miny, w_maxy;
            logic signed [COORD_W:0]   w_apx, w_apy, w_abx, w_aby;
            logic                      w_bbox;
            logic signed [COORD_W:0]   r_apx, r_apy, r_abx, r_aby;
            logic                      r_bbox1, r_en1;
            logic signed [c_xw-1:0]    w_apx_e, w_apy_e, w_abx_e, w_aby_e;
            logic signed [c_xw-1:0]    w_cross;
            logic signed [c_xw-1:0]    r_cross;
            logic                      r_bbox2, r_en2;

            assign w_minx = (r_ac_ax[g] < r_ac_bx[g]) ? r_ac_ax[g] : r_ac_bx[g];
            assign w_maxx = (r_ac_ax[g] < r_ac_bx[g]) ? r_ac_bx[g] : r_ac_ax[g];
            assign w_miny = (r_ac_ay[g] < r_ac_by[g]) ? r_ac_ay[g] : r_ac_by[g];
            assign w_maxy = (r_ac_ay[g] < r_ac_by[g]) ? r_ac_by[g] : r_ac_ay[g];
            assign w_bbox = (w_px >= w_minx) && (w_px <= w_maxx) &&
                            (w_py >= w_miny) && (w_py <= w_maxy);

            // One extra bit makes every vertex difference exact.
            assign w_apx = {w_px[COORD_W-1], w_px} - {r_ac_ax[g][COORD_W-1], r_ac_ax[g]};
            assign w_apy = {w_py[COORD_W-1], w_py} - {r_ac_ay[g][COORD_W-1], r_ac_ay[g]};
            assign w_abx = {r_ac_bx[g][COORD_W-1], r_ac_bx[g]} - {r_ac_ax[g][COORD_W-1], r_ac_ax[g]};
            assign w_aby = {r_ac_by[g][COORD_W-1], r_ac_by[g]} - {r_ac_ay[g][COORD_W-1], r_ac_ay[g]};

            assign w_apx_e = c_xw'(r_apx);
            assign w_apy_e = c_xw'(r_apy);
            assign w_abx_e = c_xw'(r_abx);
            assign w_aby_e = c_xw'(r_aby);
            assign w_cross = (w_abx_e * w_apy_e) - (w_apx_e * w_aby_e);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_apx   <= '0;
                    r_apy   <= '0;
                    r_abx   <= '0;
                    r_aby   <= '0;
                    r_bbox1 <= 1'b0;
                    r_en1   <= 1'b0;
                    r_cross <= '0;
                    r_bbox2 <= 1'b0;
                    r_en2   <= 1'b0;
                end else begin
                    r_apx   <= w_apx;
                    r_apy   <= w_apy;
                    r_abx   <= w_abx;
                    r_aby   <= w_aby;
                    r_bbox1 <= w_bbox;
                    r_en1   <= r_ac_en[g];
                    r_cross <= w_cross;
                    r_bbox2 <= r_bbox1;
                    r_en2   <= r_en1;
                end
            end

            assign w_mask[g] = r_bbox2 && r_en2 &&
                               (r_cross > -c_thresh) && (r_cross < c_thresh);
        end
    endgenerate

    assign w_mask_q = w_mask & {NUM_SEG{r2_valid}};

    always_comb begin
        w_idx = '0;
        for (int i = NUM_SEG - 1; i >= 0; i--) begin
            if (w_mask_q[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid  <= 1'b0;
            r1_x      <= '0;
            r1_y      <= '0;
            r2_valid  <= 1'b0;
            r2_x      <= '0;
            r2_y      <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            hit       <= 1'b0;
            hit_mask  <= '0;
            hit_idx   <= '0;
        end else begin
            r1_valid  <= px_valid;
            r1_x      <= px_x;
            r1_y      <= px_y;
            r2_valid  <= r1_valid;
            r2_x      <= r1_x;
            r2_y      <= r1_y;
            out_valid <= r2_valid;
            out_x     <= r2_x;
            out_y     <= r2_y;
            hit       <= |w_mask_q;
            hit_mask  <= w_mask_q;
            hit_idx   <= w_idx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_seg_raster.sv
// ============================================================================
// Module   : tb_line_seg_raster
// Brief    : Directed self-checking bench for line_seg_raster.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_line_seg_raster;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        px_valid;
    logic [15:0] px_x, px_y;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_ax, cfg_ay, cfg_bx, cfg_by;
    logic        cfg_en;
    logic        out_valid;
    logic [15:0] out_x, out_y;
    logic        hit;
    logic [3:0]  hit_mask;
    logic [1:0]  hit_idx;

    int n_vec = 0;
    int n_err = 0;

    line_seg_raster dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .px_valid    (px_valid),
        .px_x        (px_x),
        .px_y        (px_y),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_ax      (cfg_ax),
        .cfg_ay      (cfg_ay),
        .cfg_bx      (cfg_bx),
        .cfg_by      (cfg_by),
        .cfg_en      (cfg_en),
        .out_valid   (out_valid),
        .out_x       (out_x),
        .out_y       (out_y),
        .hit         (hit),
        .hit_mask    (hit_mask),
        .hit_idx     (hit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int idx, input int ax, input int ay, input int bx, input int by,
                       input logic en, input logic fs);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_idx     = idx[1:0];
        cfg_ax      = ax[15:0];
        cfg_ay      = ay[15:0];
        cfg_bx      = bx[15:0];
        cfg_by      = by[15:0];
        cfg_en      = en;
        frame_start = fs;
        @(posedge clk);
        #1;
        cfg_we      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    // One isolated pixel; result sampled just after the third edge.
    task automatic send(input string tag, input int x, input int y, input logic [3:0] m);
        logic [1:0] ei;
        ei = 2'd0;
        for (int i = 3; i >= 0; i--) if (m[i]) ei = 2'(i);
        @(negedge clk);
        px_valid = 1'b1;
        px_x     = x[15:0];
        px_y     = y[15:0];
        @(posedge clk);
        #1;
        px_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".x"}, out_x, x[15:0]);
        chk({tag, ".y"}, out_y, y[15:0]);
        chk({tag, ".mask"}, hit_mask, m);
        chk({tag, ".hit"}, hit, |m);
        chk({tag, ".idx"}, hit_idx, ei);
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; px_valid = 1'b0; px_x = '0; px_y = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_ax = '0; cfg_ay = '0; cfg_bx = '0; cfg_by = '0;
        cfg_en = 1'b0;
        #12;
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.hit", hit, 1'b0);
        chk("rst.mask", hit_mask, 4'h0);
        chk("rst.idx", hit_idx, 2'd0);
        chk("rst.x", out_x, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Five back-to-back pixels, nothing enabled
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            px_valid = (c < 5);
            px_x     = 16'(c);
            px_y     = 16'(c);
            @(posedge clk);
            #1;
            chk("burst.valid", out_valid, (c >= 2 && c <= 6));
            chk("burst.hit", hit, 1'b0);
        end
        @(negedge clk);
        px_valid = 1'b0;

        // Single segment, tolerance and bbox
        cfg(0, 10, 10, 100, 50, 1'b1, 1'b0);
        send("pre_commit", 55, 30, 4'b0000);
        commit();
        send("on_line", 55, 30, 4'b0001);
        send("tol_in", 55, 40, 4'b0001);
        send("tol_out", 55, 45, 4'b0000);
        send("bbox_out", 110, 54, 4'b0000);
        send("vertex", 10, 10, 4'b0001);

        // Two slots covering the same vertical line
        cfg(1, 0, 0, 0, 100, 1'b1, 1'b0);
        cfg(3, 0, 100, 0, 0, 1'b1, 1'b0);
        commit();
        send("dual", 0, 20, 4'b1010);
        send("dual_end", 0, 100, 4'b1010);
        send("dual_past", 0, 101, 4'b0000);

        // Write coinciding with commit lands only in shadow
        cfg(2, 0, 0, 1024, 1, 1'b1, 1'b1);
        send("wr_fs_old", 1, 1, 4'b0000);
        commit();
        send("wr_fs_new", 1, 1, 4'b0100);
        send("thr_pos", 0, 1, 4'b1010);
        send("thr_neg", 1024, 0, 4'b0000);
        send("thr_neg_in", 1023, 0, 4'b0100);

        // Full-range negative segment
        cfg(0, -32768, -32768, 32767, 32767, 1'b1, 1'b0);
        commit();
        send("neg_origin", 0, 0, 4'b1111);
        send("neg_off", 0, 1, 4'b1010);
        send("neg_on", -5, -5, 4'b0001);
        send("neg_miss", -5, -4, 4'b0000);

        // Commit while a pixel is in flight
        cfg(0, -32768, -32768, 32767, 32767, 1'b0, 1'b0);
        @(negedge clk);
        px_valid = 1'b1; px_x = 16'hFFFB; px_y = 16'hFFFB;
        @(posedge clk);
        #1;
        px_valid = 1'b0; frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        chk("inflight.valid", out_valid, 1'b1);
        chk("inflight.mask", hit_mask, 4'b0001);
        send("after_fs", -5, -5, 4'b0000);

        // Asynchronous reset with hits in flight
        @(negedge clk);
        px_valid = 1'b1; px_x = 16'd0; px_y = 16'd20;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        chk("pre_rst.hit", hit, 1'b1);
        chk("pre_rst.mask", hit_mask, 4'b1010);
        rst_n = 1'b0;
        #1;
        chk("async_rst.valid", out_valid, 1'b0);
        chk("async_rst.hit", hit, 1'b0);
        chk("async_rst.mask", hit_mask, 4'b0000);
        chk("async_rst.x", out_x, 16'h0);
        @(negedge clk);
        rst_n = 1'b1; px_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #1;
        chk("post_rst.valid", out_valid, 1'b0);
        send("post_rst_act", 0, 20, 4'b0000);
        commit();
        send("post_rst_sh", 0, 20, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
